// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Purpose
//   Owns the architectural PC on the consumer side of the next-PC path.
//   Issues sequential fetch requests to instruction memory with a
//   valid/ready handshake. Resolved control-transfer targets from the
//   target adder redirect fetch. A fixed-length Flush squashes wrong-path
//   work. A target that is not word aligned parks the block in an error
//   state until reset. PC + PC_STEP is returned to the adder.
//
// Parameters
//   PC_WIDTH     width of the PC and target buses
//   RESET_PC     PC loaded on reset
//   PC_STEP      sequential increment in bytes
//   FLUSH_DEPTH  cycles Flush is held per redirect (1..7)
//
// Ports
//   Clk              in   rising-edge clock
//   Reset            in   synchronous, active-high reset
//   Stall            in   hazard stall; blocks new requests, never withdraws one
//   RedirectValid    in   resolved control transfer this cycle
//   RedirectControl  in   0=branch 1=jr 2=jump 3=none
//   RedirectTarget   in   target address from the adder
//   FetchReady       in   imem accepts a request this cycle
//   FetchValid       out  fetch request valid
//   FetchPC          out  address of the fetch request
//   PCPlus4          out  FetchPC + PC_STEP (combinational)
//   Flush            out  squash younger pipeline slots
//   RedirectAck      out  one-cycle pulse when a redirect is captured
//   Misaligned       out  sticky: a captured target had [1:0] != 0
//   RedirectCount    out  saturating count of captured redirects
//                         (present only when REDIRECT_COUNT_EN is defined)
//
// Configuration macro
//   REDIRECT_COUNT_EN  adds the RedirectCount port and its counter.
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int                     PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int                     PC_STEP     = 4,
    parameter int                     FLUSH_DEPTH = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                RedirectValid,
    input  logic [1:0]          RedirectControl,
    input  logic [PC_WIDTH-1:0] RedirectTarget,
    input  logic                FetchReady,
    output logic                FetchValid,
    output logic [PC_WIDTH-1:0] FetchPC,
    output logic [PC_WIDTH-1:0] PCPlus4,
    output logic                Flush,
    output logic                RedirectAck,
    output logic                Misaligned
`ifdef REDIRECT_COUNT_EN
    ,
    output logic [15:0]         RedirectCount
`endif
);

    localparam logic [PC_WIDTH-1:0] STEP_C     = PC_WIDTH'(PC_STEP);
    localparam logic [2:0]          FLUSH_INIT = 3'(FLUSH_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [PC_WIDTH-1:0]   pc_s;
    logic                  fetch_valid_r;
    logic                  fetch_valid_s;
    logic                  flush_r;
    logic                  flush_s;
    logic                  ack_r;
    logic                  ack_s;
    logic                  misaligned_r;
    logic                  misaligned_s;
    logic [2:0]            flush_cnt_r;
    logic [2:0]            flush_cnt_s;
    logic                  capture_s;
    logic                  transfer_s;

    // Redirects are only believed in RUN; in FLUSH they come from the squashed path.
    assign capture_s  = (state_r == ST_RUN) && RedirectValid && (RedirectControl != 2'd3);
    assign transfer_s = fetch_valid_r && FetchReady;

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        fetch_valid_s = fetch_valid_r;
        flush_s       = flush_r;
        ack_s         = 1'b0;
        misaligned_s  = misaligned_r;
        flush_cnt_s   = flush_cnt_r;

        case (state_r)
            ST_RUN: begin
                flush_s = 1'b0;
                if (capture_s) begin
                    // Redirect outranks a same-cycle transfer: the accepted
                    // fetch is squashed and the PC does not step past it.
                    pc_s          = RedirectTarget;
                    ack_s         = 1'b1;
                    flush_s       = 1'b1;
                    fetch_valid_s = 1'b0;
                    if (RedirectTarget[1:0] != 2'b00) begin
                        misaligned_s = 1'b1;
                        state_s      = ST_ERROR;
                    end else begin
                        state_s     = ST_FLUSH;
                        flush_cnt_s = FLUSH_INIT;
                    end
                end else if (transfer_s) begin
                    pc_s          = pc_r + STEP_C;
                    fetch_valid_s = !Stall;
                end else if (fetch_valid_r) begin
                    // A raised request stays up until accepted, stall or not.
                    fetch_valid_s = 1'b1;
                end else begin
                    fetch_valid_s = !Stall;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r <= 3'd1) begin
                    state_s       = ST_RUN;
                    flush_s       = 1'b0;
                    fetch_valid_s = !Stall;
                    flush_cnt_s   = 3'd0;
                end else begin
                    flush_cnt_s   = flush_cnt_r - 3'd1;
                    flush_s       = 1'b1;
                    fetch_valid_s = 1'b0;
                end
            end
            ST_ERROR: begin
                flush_s       = 1'b0;
                fetch_valid_s = 1'b0;
            end
            default: begin
                state_s       = ST_RUN;
                flush_s       = 1'b0;
                fetch_valid_s = 1'b0;
                flush_cnt_s   = 3'd0;
            end
        endcase
    end

    // State and output registers; reset overrides every input, including mid-flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            fetch_valid_r <= 1'b0;
            flush_r       <= 1'b0;
            ack_r         <= 1'b0;
            misaligned_r  <= 1'b0;
            flush_cnt_r   <= 3'd0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            fetch_valid_r <= fetch_valid_s;
            flush_r       <= flush_s;
            ack_r         <= ack_s;
            misaligned_r  <= misaligned_s;
            flush_cnt_r   <= flush_cnt_s;
        end
    end

    assign FetchValid  = fetch_valid_r;
    assign FetchPC     = pc_r;
    assign PCPlus4     = pc_r + STEP_C;
    assign Flush       = flush_r;
    assign RedirectAck = ack_r;
    assign Misaligned  = misaligned_r;

`ifdef REDIRECT_COUNT_EN
    logic [15:0] redirect_count_r;

    // Saturating count of captured redirects; moves in step with RedirectAck.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            redirect_count_r <= 16'd0;
        end else if (ack_s && (redirect_count_r != 16'hFFFF)) begin
            redirect_count_r <= redirect_count_r + 16'd1;
        end else begin
            redirect_count_r <= redirect_count_r;
        end
    end

    assign RedirectCount = redirect_count_r;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_control;
    logic [31:0] redirect_target;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        redirect_ack;
    logic        misaligned;
`ifdef REDIRECT_COUNT_EN
    logic [15:0] redirect_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    int          flush_cycles;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .Clk             (clk),
        .Reset           (reset),
        .Stall           (stall),
        .RedirectValid   (redirect_valid),
        .RedirectControl (redirect_control),
        .RedirectTarget  (redirect_target),
        .FetchReady      (fetch_ready),
        .FetchValid      (fetch_valid),
        .FetchPC         (fetch_pc),
        .PCPlus4         (pc_plus4),
        .Flush           (flush),
        .RedirectAck     (redirect_ack),
        .Misaligned      (misaligned)
`ifdef REDIRECT_COUNT_EN
        ,
        .RedirectCount   (redirect_count)
`endif
    );

    // advance one clock and settle just after the edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_control = 2'd3; redirect_target = 32'h0; fetch_ready = 1'b0;
        cycle();
        cycle();
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", fetch_valid); end
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", fetch_pc); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pcplus4 got %h expected 4", pc_plus4); end
        checks++; if ({flush, redirect_ack, misaligned} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {flush, redirect_ack, misaligned}); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        fetch_ready = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (fetch_valid && fetch_ready) begin
                exp = exp_q.pop_front();
                checks++; if (fetch_pc !== exp) begin errors++; $display("FAIL seq_pc got %h expected %h", fetch_pc, exp); end
                checks++; if (pc_plus4 !== exp + 32'd4) begin errors++; $display("FAIL seq_pcplus4 got %h expected %h", pc_plus4, exp + 32'd4); end
                checks++; if (flush !== 1'b0) begin errors++; $display("FAIL seq_flush got %b expected 0", flush); end
            end
            if (exp_q.size() > 0) cycle();
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL seq_timeout left %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_hold();
        cycle();                       // PC 0x10 is now presented
        fetch_ready = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h10) begin errors++; $display("FAIL hold got v=%b pc=%h expected v=1 pc=00000010", fetch_valid, fetch_pc); end
            stall = ~stall;
        end
        stall = 1'b0;
        fetch_ready = 1'b1;
        exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (fetch_valid && fetch_ready) begin
                exp = exp_q.pop_front();
                checks++; if (fetch_pc !== exp) begin errors++; $display("FAIL hold_resume_pc got %h expected %h", fetch_pc, exp); end
            end
            if (exp_q.size() > 0) cycle();
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL hold_timeout left %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_redirect();
        cycle();                       // 0x18 pending with ready high: gets squashed
        redirect_valid = 1'b1; redirect_control = 2'd0; redirect_target = 32'h200;
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        cycle();
        redirect_valid = 1'b0;
        checks++; if (redirect_ack !== 1'b1) begin errors++; $display("FAIL redir_ack got %b expected 1", redirect_ack); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_low got %b expected 0", fetch_valid); end
        flush_cycles = flush ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (!flush) break;
            flush_cycles++;
            checks++; if (redirect_ack !== 1'b0) begin errors++; $display("FAIL redir_ack_pulse got %b expected 0", redirect_ack); end
        end
        checks++; if (flush_cycles != 2) begin errors++; $display("FAIL redir_flush_len got %0d expected 2", flush_cycles); end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (fetch_valid && fetch_ready) begin
                exp = exp_q.pop_front();
                checks++; if (fetch_pc !== exp) begin errors++; $display("FAIL redir_pc got %h expected %h", fetch_pc, exp); end
            end
            if (exp_q.size() > 0) cycle();
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout left %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_flush_ignore();
        cycle();
        redirect_valid = 1'b1; redirect_control = 2'd1; redirect_target = 32'h40;
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        cycle();
        checks++; if (redirect_ack !== 1'b1) begin errors++; $display("FAIL fi_first_ack got %b expected 1", redirect_ack); end
        redirect_control = 2'd2; redirect_target = 32'h80;   // wrong-path redirect
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (redirect_ack !== 1'b0) begin errors++; $display("FAIL fi_ignored_ack got %b expected 0", redirect_ack); end
        end
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (fetch_valid && fetch_ready) begin
                exp = exp_q.pop_front();
                checks++; if (fetch_pc !== exp) begin errors++; $display("FAIL fi_pc got %h expected %h", fetch_pc, exp); end
            end
            if (exp_q.size() > 0) cycle();
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL fi_timeout left %0d expected 0", exp_q.size()); exp_q.delete(); end
        // kind 3 (none) with RedirectValid high must not disturb sequencing
        cycle();
        redirect_valid = 1'b1; redirect_control = 2'd3; redirect_target = 32'h80;
        exp_q.push_back(32'h48); exp_q.push_back(32'h4C); exp_q.push_back(32'h50);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (fetch_valid && fetch_ready) begin
                exp = exp_q.pop_front();
                checks++; if (fetch_pc !== exp || flush !== 1'b0 || redirect_ack !== 1'b0) begin errors++; $display("FAIL kind3 got pc=%h f=%b a=%b expected pc=%h f=0 a=0", fetch_pc, flush, redirect_ack, exp); end
            end
            if (exp_q.size() > 0) cycle();
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL kind3_timeout left %0d expected 0", exp_q.size()); exp_q.delete(); end
        redirect_valid = 1'b0;
    endtask

    task automatic test_misaligned();
        cycle();
        redirect_valid = 1'b1; redirect_control = 2'd0; redirect_target = 32'h42;
        cycle();
        redirect_valid = 1'b0;
        checks++; if (misaligned !== 1'b1 || redirect_ack !== 1'b1) begin errors++; $display("FAIL mis_capture got m=%b a=%b expected m=1 a=1", misaligned, redirect_ack); end
        flush_cycles = flush ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (flush) flush_cycles++;
            checks++; if (fetch_valid !== 1'b0 || misaligned !== 1'b1) begin errors++; $display("FAIL mis_error got v=%b m=%b expected v=0 m=1", fetch_valid, misaligned); end
        end
        checks++; if (flush_cycles != 1) begin errors++; $display("FAIL mis_flush_len got %0d expected 1", flush_cycles); end
`ifdef REDIRECT_COUNT_EN
        checks++; if (redirect_count !== 16'd3) begin errors++; $display("FAIL redirect_count got %0d expected 3", redirect_count); end
`endif
        reset = 1'b1;
        cycle();
        checks++; if (fetch_pc !== 32'h0 || misaligned !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_reset got pc=%h m=%b v=%b expected pc=0 m=0 v=0", fetch_pc, misaligned, fetch_valid); end
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        cycle();
        redirect_valid = 1'b1; redirect_control = 2'd2; redirect_target = 32'hFFFF_FFF8;
        exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && flush; i++) cycle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (fetch_valid && fetch_ready) begin
                exp = exp_q.pop_front();
                checks++; if (fetch_pc !== exp || pc_plus4 !== exp + 32'd4) begin errors++; $display("FAIL wrap got pc=%h p4=%h expected pc=%h p4=%h", fetch_pc, pc_plus4, exp, exp + 32'd4); end
            end
            if (exp_q.size() > 0) cycle();
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout left %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid_flush();
        cycle();
        redirect_valid = 1'b1; redirect_control = 2'd0; redirect_target = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        reset = 1'b1;
        cycle();
        checks++; if (flush !== 1'b0 || redirect_ack !== 1'b0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_flush got f=%b a=%b v=%b pc=%h expected f=0 a=0 v=0 pc=0", flush, redirect_ack, fetch_valid, fetch_pc); end
        reset = 1'b0;
        cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_resume got v=%b pc=%h expected v=1 pc=0", fetch_valid, fetch_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold();
        test_redirect();
        test_flush_ignore();
        test_misaligned();
        test_wrap();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
